// File: rtl/des_pkg.sv
// Shared DES key-schedule constants, PC-1/PC-2 tables and helper functions.
// pc1() and key_parity_err() are used only when DES_KEYSCHED_PC1_EN is defined.
package des_pkg;

  localparam int unsigned DES_KEY_W    = 56;
  localparam int unsigned DES_HALF_W   = DES_KEY_W / 2;
  localparam int unsigned DES_SUBKEY_W = 48;
  localparam int unsigned DES_RAW_W    = 64;
  localparam int unsigned DES_ROUNDS   = 16;
  localparam int unsigned RND_W        = 5;
  localparam int unsigned MASK_W       = 16;

  // Rounds 1, 2, 9 and 16 rotate by one; every other round rotates by two.
  localparam logic [MASK_W-1:0] DES_SHIFT1_MASK = 16'b1000_0001_0000_0011;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

  localparam int unsigned PC1_TABLE [DES_KEY_W] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TABLE [DES_SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Table entries are 1-based with bit 1 being the MSB of the input word.
  function automatic logic [DES_KEY_W-1:0] pc1(input logic [DES_RAW_W-1:0] key);
    logic [DES_KEY_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < DES_KEY_W; i++) begin
      res = {res[DES_KEY_W-2:0], key[6'(DES_RAW_W - PC1_TABLE[i])]};
    end
    return res;
  endfunction

  function automatic logic [DES_SUBKEY_W-1:0] pc2(input logic [DES_KEY_W-1:0] cd);
    logic [DES_SUBKEY_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < DES_SUBKEY_W; i++) begin
      res = {res[DES_SUBKEY_W-2:0], cd[6'(DES_KEY_W - PC2_TABLE[i])]};
    end
    return res;
  endfunction

  function automatic logic [1:0] s(input logic [MASK_W-1:0] mask,
                                   input logic [RND_W-1:0]  r);
    return mask[4'(r - RND_W'(1))] ? 2'd1 : 2'd2;
  endfunction

  function automatic int unsigned shift_sum(input logic [MASK_W-1:0] mask,
                                            input int unsigned       rounds);
    int unsigned acc;
    acc = 0;
    for (int unsigned r = 1; r <= rounds; r++) begin
      acc = acc + 32'(s(mask, RND_W'(r)));
    end
    return acc;
  endfunction

  // A DES key byte must carry odd parity.
  function automatic logic key_parity_err(input logic [DES_RAW_W-1:0] key);
    logic [DES_RAW_W-1:0] k;
    logic                 err;
    k   = key;
    err = 1'b0;
    for (int unsigned b = 0; b < DES_RAW_W / 8; b++) begin
      err = err | ~(^k[7:0]);
      k   = k >> 8;
    end
    return err;
  endfunction

endpackage

// File: rtl/des_half_rotator.sv
// Circular rotate of one 28-bit key half, left or right by 0, 1 or 2 bits.
module des_half_rotator
  import des_pkg::*;
(
  input  logic [DES_HALF_W-1:0] data_i,
  input  logic                  dir_right_i,
  input  logic [1:0]            amt_i,
  output logic [DES_HALF_W-1:0] data_o
);

  always_comb begin
    data_o = data_i;
    case ({dir_right_i, amt_i})
      3'b001:  data_o = {data_i[DES_HALF_W-2:0], data_i[DES_HALF_W-1]};
      3'b010:  data_o = {data_i[DES_HALF_W-3:0], data_i[DES_HALF_W-1 -: 2]};
      3'b101:  data_o = {data_i[0], data_i[DES_HALF_W-1:1]};
      3'b110:  data_o = {data_i[1:0], data_i[DES_HALF_W-1:2]};
      default: data_o = data_i;
    endcase
  end

endmodule

// File: rtl/des_key_scheduler.sv
// Sequential DES key schedule: one subkey per sk handshake from a shared C/D rotator.
// Define DES_KEYSCHED_PC1_EN to take a raw 64-bit key (PC-1 applied here) and report parity_err_o.
module des_key_scheduler
  import des_pkg::*;
#(
  parameter int unsigned        KEY_W       = DES_KEY_W,
  parameter int unsigned        SUBKEY_W    = DES_SUBKEY_W,
  parameter int unsigned        ROUNDS      = DES_ROUNDS,
  parameter logic [MASK_W-1:0]  SHIFT1_MASK = DES_SHIFT1_MASK
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid_i,
  output logic                 load_ready_o,
`ifdef DES_KEYSCHED_PC1_EN
  input  logic [DES_RAW_W-1:0] load_key_i,
  output logic                 parity_err_o,
`else
  input  logic [KEY_W-1:0]     load_key_i,
`endif
  input  logic                 load_decrypt_i,
  output logic                 sk_valid_o,
  input  logic                 sk_ready_i,
  output logic [SUBKEY_W-1:0]  sk_data_o,
  output logic [RND_W-1:0]     sk_round_o,
  output logic                 sk_last_o
);

  localparam int unsigned      HALF_W      = KEY_W / 2;
  localparam logic [RND_W-1:0] LAST_RND    = RND_W'(ROUNDS);
  localparam int unsigned      SHIFT_TOTAL = shift_sum(SHIFT1_MASK, ROUNDS);

  // Elaboration-time sanity checks on the configuration.
  if (KEY_W != DES_KEY_W || SUBKEY_W != DES_SUBKEY_W) begin : g_chk_width
    $error("des_key_scheduler: KEY_W/SUBKEY_W must match the DES tables");
  end
  if (ROUNDS > 31) begin : g_chk_rounds_max
    $error("des_key_scheduler: ROUNDS must not exceed 31");
  end
  if (ROUNDS > MASK_W) begin : g_chk_rounds_mask
    $error("des_key_scheduler: ROUNDS exceeds SHIFT1_MASK width");
  end
  if (SHIFT_TOTAL != HALF_W) begin : g_chk_shift_sum
    $error("des_key_scheduler: total rotation must equal KEY_W/2");
  end

  state_e                state_q, state_d;
  logic [KEY_W-1:0]      cd_q, cd_d;
  logic                  mode_q, mode_d;
  logic                  load_ready_q, load_ready_d;
  logic                  sk_valid_q, sk_valid_d;
  logic [SUBKEY_W-1:0]   sk_data_q, sk_data_d;
  logic [RND_W-1:0]      sk_round_q, sk_round_d;
  logic                  sk_last_q, sk_last_d;

  logic [KEY_W-1:0]      key_c;
  logic [KEY_W-1:0]      rot_src_c;
  logic [KEY_W-1:0]      rot_c;
  logic                  rot_right_c;
  logic [1:0]            rot_amt_c;
  logic                  load_fire_c;
  logic                  sk_fire_c;

`ifdef DES_KEYSCHED_PC1_EN
  logic parity_q;

  assign key_c = pc1(load_key_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (load_fire_c) begin
      parity_q <= key_parity_err(load_key_i);
    end
  end

  assign parity_err_o = parity_q;
`else
  assign key_c = load_key_i;
`endif

  assign load_fire_c = load_valid_i && load_ready_q;
  assign sk_fire_c   = sk_valid_q && sk_ready_i;

  // In IDLE the rotator pre-rotates the incoming key for round 1; in RUN it steps C/D.
  always_comb begin
    rot_src_c   = cd_q;
    rot_right_c = 1'b0;
    rot_amt_c   = 2'd0;
    if (state_q == ST_IDLE) begin
      rot_src_c = key_c;
      rot_amt_c = load_decrypt_i ? 2'd0 : s(SHIFT1_MASK, RND_W'(1));
    end else if (mode_q) begin
      rot_right_c = 1'b1;
      rot_amt_c   = s(SHIFT1_MASK, RND_W'(ROUNDS + 1) - sk_round_q);
    end else begin
      rot_amt_c   = s(SHIFT1_MASK, sk_round_q + RND_W'(1));
    end
  end

  des_half_rotator u_rot_c (
    .data_i      (rot_src_c[KEY_W-1 -: HALF_W]),
    .dir_right_i (rot_right_c),
    .amt_i       (rot_amt_c),
    .data_o      (rot_c[KEY_W-1 -: HALF_W])
  );

  des_half_rotator u_rot_d (
    .data_i      (rot_src_c[HALF_W-1:0]),
    .dir_right_i (rot_right_c),
    .amt_i       (rot_amt_c),
    .data_o      (rot_c[HALF_W-1:0])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load_fire_c) state_d = ST_RUN;
      ST_RUN:  if (sk_fire_c && (sk_round_q == LAST_RND)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cd_d         = cd_q;
    mode_d       = mode_q;
    load_ready_d = load_ready_q;
    sk_valid_d   = sk_valid_q;
    sk_data_d    = sk_data_q;
    sk_round_d   = sk_round_q;
    sk_last_d    = sk_last_q;
    case (state_q)
      ST_IDLE: begin
        if (load_fire_c) begin
          mode_d       = load_decrypt_i;
          cd_d         = rot_c;
          load_ready_d = 1'b0;
          sk_valid_d   = 1'b1;
          sk_data_d    = pc2(rot_c);
          sk_round_d   = RND_W'(1);
          sk_last_d    = (LAST_RND == RND_W'(1));
        end
      end
      ST_RUN: begin
        if (sk_fire_c) begin
          if (sk_round_q == LAST_RND) begin
            load_ready_d = 1'b1;
            sk_valid_d   = 1'b0;
            sk_last_d    = 1'b0;
          end else begin
            cd_d       = rot_c;
            sk_data_d  = pc2(rot_c);
            sk_round_d = sk_round_q + RND_W'(1);
            sk_last_d  = ((sk_round_q + RND_W'(1)) == LAST_RND);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd_q         <= '0;
      mode_q       <= 1'b0;
      load_ready_q <= 1'b1;
      sk_valid_q   <= 1'b0;
      sk_data_q    <= '0;
      sk_round_q   <= '0;
      sk_last_q    <= 1'b0;
    end else begin
      cd_q         <= cd_d;
      mode_q       <= mode_d;
      load_ready_q <= load_ready_d;
      sk_valid_q   <= sk_valid_d;
      sk_data_q    <= sk_data_d;
      sk_round_q   <= sk_round_d;
      sk_last_q    <= sk_last_d;
    end
  end

  assign load_ready_o = load_ready_q;
  assign sk_valid_o   = sk_valid_q;
  assign sk_data_o    = sk_data_q;
  assign sk_round_o   = sk_round_q;
  assign sk_last_o    = sk_last_q;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Directed bench for des_key_scheduler using the classic 0x133457799BBCDFF1 schedule.
module tb_des_key_scheduler;

`ifdef DES_KEYSCHED_PC1_EN
  localparam int KIN_W = 64;
  localparam logic [KIN_W-1:0] KEY_GOOD = 64'h133457799BBCDFF1;
  localparam logic [KIN_W-1:0] KEY_BADP = 64'h133457799BBCDFF0;
`else
  localparam int KIN_W = 56;
  localparam logic [KIN_W-1:0] KEY_GOOD = 56'hF0CCAAF556678F;
`endif

  localparam logic [47:0] EXP_K [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  logic             clk;
  logic             rst_n;
  logic             load_valid;
  logic             load_ready;
  logic [KIN_W-1:0] load_key;
  logic             load_decrypt;
  logic             sk_valid;
  logic             sk_ready;
  logic [47:0]      sk_data;
  logic [4:0]       sk_round;
  logic             sk_last;
`ifdef DES_KEYSCHED_PC1_EN
  logic             parity_err;
`endif

  int tests = 0;
  int fails = 0;

  des_key_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_valid_i   (load_valid),
    .load_ready_o   (load_ready),
    .load_key_i     (load_key),
`ifdef DES_KEYSCHED_PC1_EN
    .parity_err_o   (parity_err),
`endif
    .load_decrypt_i (load_decrypt),
    .sk_valid_o     (sk_valid),
    .sk_ready_i     (sk_ready),
    .sk_data_o      (sk_data),
    .sk_round_o     (sk_round),
    .sk_last_o      (sk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  // Offer a key from a negedge; returns at the negedge after acceptance.
  task automatic do_load(input logic [KIN_W-1:0] key, input logic dec, output bit ok);
    bit rdy;
    ok = 1'b0;
    load_key     = key;
    load_decrypt = dec;
    load_valid   = 1'b1;
    for (int c = 0; c < 40 && !ok; c++) begin
      rdy = load_ready;
      @(posedge clk);
      ok = rdy;
      @(negedge clk);
    end
    load_valid = 1'b0;
  endtask

  task automatic drain(output bit idle);
    sk_ready = 1'b1;
    idle = 1'b0;
    for (int c = 0; c < 40 && !idle; c++) begin
      if (!sk_valid) idle = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    load_valid = 1'b0; load_key = '0; load_decrypt = 1'b0; sk_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({load_ready, sk_valid, sk_last, sk_round, sk_data} !== {1'b1, 1'b0, 1'b0, 5'd0, 48'd0}) begin
      fails++;
      $display("FAIL reset_hold: rdy=%b v=%b l=%b r=%0d d=%h, want rdy=1 v=0 l=0 r=0 d=0",
               load_ready, sk_valid, sk_last, sk_round, sk_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({load_ready, sk_valid, sk_last, sk_round, sk_data} !== {1'b1, 1'b0, 1'b0, 5'd0, 48'd0}) begin
      fails++;
      $display("FAIL reset_release: rdy=%b v=%b l=%b r=%0d d=%h, want rdy=1 v=0 l=0 r=0 d=0",
               load_ready, sk_valid, sk_last, sk_round, sk_data);
    end
`ifdef DES_KEYSCHED_PC1_EN
    tests++;
    if (parity_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_parity: got %b want 0", parity_err);
    end
`endif
  endtask

  task automatic test_encrypt();
    bit ok;
    sk_ready = 1'b1;
    do_load(KEY_GOOD, 1'b0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL enc_load: got not accepted want accepted"); end
`ifdef DES_KEYSCHED_PC1_EN
    tests++;
    if (parity_err !== 1'b0) begin fails++; $display("FAIL enc_parity: got %b want 0", parity_err); end
`endif
    for (int r = 1; r <= 16; r++) begin
      tests++;
      if ({load_ready, sk_valid, sk_last, sk_round, sk_data} !==
          {1'b0, 1'b1, (r == 16), 5'(r), EXP_K[4'(r-1)]}) begin
        fails++;
        $display("FAIL enc_round%0d: got rdy=%b v=%b l=%b r=%0d d=%h want rdy=0 v=1 l=%b r=%0d d=%h",
                 r, load_ready, sk_valid, sk_last, sk_round, sk_data, (r == 16), r, EXP_K[4'(r-1)]);
      end
      @(negedge clk);
    end
    tests++;
    if ({load_ready, sk_valid, sk_last} !== 3'b100) begin
      fails++;
      $display("FAIL enc_idle: got rdy=%b v=%b l=%b want rdy=1 v=0 l=0", load_ready, sk_valid, sk_last);
    end
  endtask

  task automatic test_decrypt();
    bit ok;
    sk_ready = 1'b1;
    do_load(KEY_GOOD, 1'b1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL dec_load: got not accepted want accepted"); end
    for (int r = 1; r <= 16; r++) begin
      tests++;
      if ({sk_valid, sk_last, sk_round, sk_data} !== {1'b1, (r == 16), 5'(r), EXP_K[4'(16-r)]}) begin
        fails++;
        $display("FAIL dec_round%0d: got v=%b l=%b r=%0d d=%h want v=1 l=%b r=%0d d=%h",
                 r, sk_valid, sk_last, sk_round, sk_data, (r == 16), r, EXP_K[4'(16-r)]);
      end
      @(negedge clk);
    end
    tests++;
    if ({load_ready, sk_valid, sk_last} !== 3'b100) begin
      fails++;
      $display("FAIL dec_idle: got rdy=%b v=%b l=%b want rdy=1 v=0 l=0", load_ready, sk_valid, sk_last);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int exp_r;
    int stalls;
    sk_ready = 1'b1;
    do_load(KEY_GOOD, 1'b0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL bp_load: got not accepted want accepted"); end
    exp_r  = 1;
    stalls = 0;
    for (int c = 0; c < 400 && exp_r <= 16; c++) begin
      tests++;
      if ({sk_valid, sk_last, sk_round, sk_data} !== {1'b1, (exp_r == 16), 5'(exp_r), EXP_K[4'(exp_r-1)]}) begin
        fails++;
        $display("FAIL bp_cycle%0d: got v=%b l=%b r=%0d d=%h want v=1 l=%b r=%0d d=%h",
                 c, sk_valid, sk_last, sk_round, sk_data, (exp_r == 16), exp_r, EXP_K[4'(exp_r-1)]);
      end
      sk_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      if (sk_ready) exp_r++;
      else stalls++;
      @(negedge clk);
    end
    tests++;
    if (exp_r != 17 || sk_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_done: got next_round=%0d v=%b want next_round=17 v=0", exp_r, sk_valid);
    end
    sk_ready = 1'b1;
  endtask

  task automatic test_busy_load();
    bit ok;
    sk_ready = 1'b1;
    do_load(KEY_GOOD, 1'b0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL busy_load1: got not accepted want accepted"); end
    load_key = KEY_GOOD; load_decrypt = 1'b1; load_valid = 1'b1;
    for (int r = 1; r <= 16; r++) begin
      tests++;
      if ({load_ready, sk_valid, sk_round, sk_data} !== {1'b0, 1'b1, 5'(r), EXP_K[4'(r-1)]}) begin
        fails++;
        $display("FAIL busy_round%0d: got rdy=%b v=%b r=%0d d=%h want rdy=0 v=1 r=%0d d=%h",
                 r, load_ready, sk_valid, sk_round, sk_data, r, EXP_K[4'(r-1)]);
      end
      @(negedge clk);
    end
    tests++;
    if ({load_ready, sk_valid} !== 2'b10) begin
      fails++;
      $display("FAIL busy_gap: got rdy=%b v=%b want rdy=1 v=0", load_ready, sk_valid);
    end
    @(negedge clk);
    load_valid = 1'b0;
    for (int r = 1; r <= 16; r++) begin
      tests++;
      if ({load_ready, sk_valid, sk_round, sk_data} !== {1'b0, 1'b1, 5'(r), EXP_K[4'(16-r)]}) begin
        fails++;
        $display("FAIL busy_second%0d: got rdy=%b v=%b r=%0d d=%h want rdy=0 v=1 r=%0d d=%h",
                 r, load_ready, sk_valid, sk_round, sk_data, r, EXP_K[4'(16-r)]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    bit idle;
    sk_ready = 1'b1;
    do_load(KEY_GOOD, 1'b0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL arst_load: got not accepted want accepted"); end
    for (int r = 1; r < 7; r++) @(negedge clk);
    sk_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({sk_valid, sk_round, sk_data} !== {1'b1, 5'd7, EXP_K[6]}) begin
      fails++;
      $display("FAIL arst_stall: got v=%b r=%0d d=%h want v=1 r=7 d=%h", sk_valid, sk_round, sk_data, EXP_K[6]);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({load_ready, sk_valid, sk_last, sk_round, sk_data} !== {1'b1, 1'b0, 1'b0, 5'd0, 48'd0}) begin
      fails++;
      $display("FAIL arst_async: got rdy=%b v=%b l=%b r=%0d d=%h want rdy=1 v=0 l=0 r=0 d=0",
               load_ready, sk_valid, sk_last, sk_round, sk_data);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    sk_ready = 1'b1;
    @(negedge clk);
    do_load(KEY_GOOD, 1'b0, ok);
    tests++;
    if ({ok, sk_valid, sk_round, sk_data} !== {1'b1, 1'b1, 5'd1, EXP_K[0]}) begin
      fails++;
      $display("FAIL arst_restart: got acc=%b v=%b r=%0d d=%h want acc=1 v=1 r=1 d=%h",
               ok, sk_valid, sk_round, sk_data, EXP_K[0]);
    end
    drain(idle);
    tests++;
    if (!idle) begin fails++; $display("FAIL arst_drain: got busy want idle"); end
  endtask

`ifdef DES_KEYSCHED_PC1_EN
  task automatic test_parity();
    bit ok;
    bit idle;
    sk_ready = 1'b1;
    do_load(KEY_BADP, 1'b0, ok);
    tests++;
    if ({ok, parity_err} !== 2'b11) begin
      fails++;
      $display("FAIL parity_bad: got acc=%b perr=%b want acc=1 perr=1", ok, parity_err);
    end
    for (int r = 1; r <= 16; r++) begin
      tests++;
      if ({sk_round, sk_data} !== {5'(r), EXP_K[4'(r-1)]}) begin
        fails++;
        $display("FAIL parity_round%0d: got r=%0d d=%h want r=%0d d=%h", r, sk_round, sk_data, r, EXP_K[4'(r-1)]);
      end
      @(negedge clk);
    end
    do_load(KEY_GOOD, 1'b0, ok);
    tests++;
    if ({ok, parity_err} !== 2'b10) begin
      fails++;
      $display("FAIL parity_clear: got acc=%b perr=%b want acc=1 perr=0", ok, parity_err);
    end
    drain(idle);
    tests++;
    if (!idle) begin fails++; $display("FAIL parity_drain: got busy want idle"); end
  endtask
`endif

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_backpressure();
    test_busy_load();
    test_async_reset();
`ifdef DES_KEYSCHED_PC1_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
